// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JREG
    } pc_sel_t;

    typedef enum logic {
        RUN,
        HOLD
    } pc_state_t;

endpackage

// File: rtl/next_pc_select.sv
// Combinational priority mux for the next PC: JR > J > branch > sequential.
module next_pc_select
    import pc_pkg::*;
#(
    parameter int unsigned NBits = 32
) (
    input  logic [NBits-1:0] pc_plus4_i,
    input  logic             jump_i,
    input  logic [NBits-1:0] jump_target_i,
    input  logic             jump_reg_i,
    input  logic [NBits-1:0] jump_reg_target_i,
    input  logic             branch_taken_i,
    input  logic [NBits-1:0] branch_target_i,
    output logic [NBits-1:0] target_o,
    output logic             redirect_o,
    output pc_sel_t          sel_o
);

    always_comb begin
        sel_o = SEL_SEQ;
        if (jump_reg_i) begin
            sel_o = SEL_JREG;
        end else if (jump_i) begin
            sel_o = SEL_JUMP;
        end else if (branch_taken_i) begin
            sel_o = SEL_BRANCH;
        end
    end

    always_comb begin
        target_o = pc_plus4_i;
        unique case (sel_o)
            SEL_SEQ:    target_o = pc_plus4_i;
            SEL_BRANCH: target_o = branch_target_i;
            SEL_JUMP:   target_o = jump_target_i;
            SEL_JREG:   target_o = jump_reg_target_i;
            default:    target_o = pc_plus4_i;
        endcase
    end

    assign redirect_o = (sel_o != SEL_SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// PC register with stall hold, deferred redirects and a one-cycle flush pulse.
// Optional target alignment and Misaligned_o when PC_ALIGN_CHECK_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      NBits    = 32,
    parameter logic [NBits-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall_i,
    input  logic             Jump_i,
    input  logic [NBits-1:0] JumpTarget_i,
    input  logic             JumpReg_i,
    input  logic [NBits-1:0] JumpRegTarget_i,
    input  logic             BranchTaken_i,
    input  logic [NBits-1:0] BranchTarget_i,
    output logic [NBits-1:0] PC_o,
    output logic [NBits-1:0] PCPlus4_o,
    output logic             Flush_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic             Misaligned_o,
`endif
    output logic             RedirectPending_o
);

    pc_state_t        state_q, state_d;
    logic [NBits-1:0] pc_q, pc_d;
    logic [NBits-1:0] pend_q, pend_d;
    logic             flush_q, flush_d;
    logic [NBits-1:0] sel_target;
    logic             redirect;
    pc_sel_t          sel;
    logic [NBits-1:0] load_tgt;

    assign PCPlus4_o = pc_q + NBits'(PC_STEP);

    next_pc_select #(
        .NBits(NBits)
    ) u_next_pc_select (
        .pc_plus4_i        (PCPlus4_o),
        .jump_i            (Jump_i),
        .jump_target_i     (JumpTarget_i),
        .jump_reg_i        (JumpReg_i),
        .jump_reg_target_i (JumpRegTarget_i),
        .branch_taken_i    (BranchTaken_i),
        .branch_target_i   (BranchTarget_i),
        .target_o          (sel_target),
        .redirect_o        (redirect),
        .sel_o             (sel)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        flush_d  = 1'b0;
        load_tgt = pc_q;
        unique case (state_q)
            RUN: begin
                if (!Stall_i) begin
                    load_tgt = sel_target;
                    flush_d  = redirect;
                end else if (redirect) begin
                    pend_d  = sel_target;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Stall_i) begin
                    // Latest redirect seen during the stall wins.
                    if (redirect) pend_d = sel_target;
                end else begin
                    load_tgt = redirect ? sel_target : pend_q;
                    flush_d  = 1'b1;
                    pend_d   = '0;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign pc_d         = {load_tgt[NBits-1:2], 2'b00};
    assign mis_d        = flush_d & (|load_tgt[1:0]);
    assign Misaligned_o = mis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end
`else
    assign pc_d = load_tgt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= PC_RESET;
            pend_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
        end
    end

    assign PC_o              = pc_q;
    assign Flush_o           = flush_q;
    assign RedirectPending_o = (state_q == HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then randomized traffic vs a model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        stall, jump, jr, br;
    logic [31:0] jt, jrt, bt;
    logic [31:0] pc, pc4;
    logic        flush, pend;

    int unsigned n_tests;
    int unsigned n_fail;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_pend_v;
    logic [31:0] m_pend;

    pc_sequencer #(
        .NBits    (32),
        .PC_RESET (RST_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Stall_i           (stall),
        .Jump_i            (jump),
        .JumpTarget_i      (jt),
        .JumpReg_i         (jr),
        .JumpRegTarget_i   (jrt),
        .BranchTaken_i     (br),
        .BranchTarget_i    (bt),
        .PC_o              (pc),
        .PCPlus4_o         (pc4),
        .Flush_o           (flush),
        .RedirectPending_o (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_flush  = 1'b0;
        m_pend_v = 1'b0;
        m_pend   = '0;
    endtask

    // One clock of the architectural rules: a redirect during a stall is remembered
    // (latest wins); when the stall lifts, a fresh redirect beats the remembered one.
    task automatic model_step();
        logic        has_req;
        logic [31:0] req;
        has_req = jr | jump | br;
        req     = jr ? jrt : (jump ? jt : bt);
        if (stall) begin
            m_flush = 1'b0;
            if (has_req) begin
                m_pend_v = 1'b1;
                m_pend   = req;
            end
        end else begin
            if (has_req) begin
                m_pc    = req;
                m_flush = 1'b1;
            end else if (m_pend_v) begin
                m_pc    = m_pend;
                m_flush = 1'b1;
            end else begin
                m_pc    = m_pc + 32'd4;
                m_flush = 1'b0;
            end
            m_pend_v = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".pc"}, pc, m_pc);
        check_eq({tag, ".pc4"}, pc4, m_pc + 32'd4);
        check_eq({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
        check_eq({tag, ".pend"}, {31'd0, pend}, {31'd0, m_pend_v});
    endtask

    task automatic drive(input logic s, input logic j, input logic [31:0] jtv, input logic r,
                         input logic [31:0] rtv, input logic b, input logic [31:0] btv);
        stall = s; jump = j; jt = jtv; jr = r; jrt = rtv; br = b; bt = btv;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        @(negedge clk);
        check_eq("rst.pc", pc, RST_PC);
        check_eq("rst.flush", {31'd0, flush}, 32'd0);
        check_eq("rst.pend", {31'd0, pend}, 32'd0);
        reset = 1'b1;

        step("seq1");
        step("seq2");
        check_eq("seq2.const", pc, 32'h0040_0008);
        step("seq3");
        check_eq("seq3.const", pc, 32'h0040_000C);

        drive(0, 1, 32'h0040_0020, 0, 0, 0, 0);
        step("jump");
        check_eq("jump.const", pc, 32'h0040_0020);
        check_eq("jump.flush", {31'd0, flush}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step("after_jump");
        check_eq("after_jump.const", pc, 32'h0040_0024);

        drive(0, 1, 32'h0040_0200, 1, 32'h0040_0300, 1, 32'h0040_0100);
        step("prio_all");
        check_eq("prio_all.const", pc, 32'h0040_0300);
        drive(0, 1, 32'h0040_0200, 0, 32'h0040_0300, 1, 32'h0040_0100);
        step("prio_nojr");
        check_eq("prio_nojr.const", pc, 32'h0040_0200);

        drive(1, 0, 0, 0, 0, 1, 32'h0040_0040);
        step("stall1");
        drive(1, 0, 0, 0, 0, 0, 0);
        step("stall2");
        step("stall3");
        check_eq("stall.pend", {31'd0, pend}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step("release");
        check_eq("release.const", pc, 32'h0040_0040);

        // Asynchronous reset while a redirect is pending
        drive(1, 1, 32'h0050_0000, 0, 0, 0, 0);
        step("hold_enter");
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst.pc", pc, RST_PC);
        check_eq("async_rst.pend", {31'd0, pend}, 32'd0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step("no_stale");
        check_eq("no_stale.const", pc, 32'h0040_0004);

        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step("wrap_jr");
        check_eq("wrap.pc4", pc4, 32'h0000_0000);
        drive(0, 0, 0, 0, 0, 0, 0);
        step("wrap_seq");
        check_eq("wrap.const", pc, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 2) == 0);
            jump  = ($urandom_range(0, 5) == 0);
            jr    = ($urandom_range(0, 7) == 0);
            br    = ($urandom_range(0, 4) == 0);
            jt    = $urandom;
            jrt   = $urandom;
            bt    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                jt  = jt & ~32'd3;
                jrt = jrt & ~32'd3;
                bt  = bt & ~32'd3;
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
